evict_buffer: RTL and testbench

Write-back evict buffer between the L1 cache controller and main memory (`mm0`). It accepts dirty 256-bit lines evicted in the WR_EVICT/RD_EVICT states into a small FIFO, and drains them to main memory over a req/ack write port. It also answers a combinational address lookup so a FILL can be forwarded from a pending eviction instead of reading stale main memory. It supports a flush handshake used by INVAL_ALL.

---
 rtl/evict_buffer_pkg.sv | 15 +
 rtl/evict_buffer_entry_ram.sv | 47 ++++
 rtl/evict_buffer.sv | 141 ++++++++++++++
 tb/tb_evict_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/evict_buffer_pkg.sv
// Shared definitions for the L1 write-back evict buffer.
// Holds the drain FSM state encoding and the default line geometry. The cache
// top and the main-memory model (mm0) use the same geometry constants.
package evict_buffer_pkg;

   localparam int EVB_LINE_AW = 26;   // main-memory line index width
   localparam int EVB_LINE_W  = 256;  // line payload width

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_REQ  = 2'd1,
      D_GAP  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/evict_buffer_entry_ram.sv
// evb_entry_ram: DEPTH x (LINE_AW + LINE_W) register array for the evict buffer.
// Ports:
//   clk                 - clock, rising edge
//   we / waddr          - write enable and entry index
//   wr_addr / wr_data   - line address and line data to store
//   ent_addr / ent_data - every entry, flattened (entry i at slice i)
// Contents are deliberately not reset; occupancy is tracked by the owner.
module evb_entry_ram #(
   parameter int DEPTH   = 4,
   parameter int LINE_AW = 26,
   parameter int LINE_W  = 256,
   parameter int PW      = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [PW-1:0]             waddr,
   input  logic [LINE_AW-1:0]        wr_addr,
   input  logic [LINE_W-1:0]         wr_data,
   output logic [DEPTH*LINE_AW-1:0]  ent_addr,
   output logic [DEPTH*LINE_W-1:0]   ent_data
);

   logic [LINE_AW-1:0] addr_q [DEPTH];
   logic [LINE_AW-1:0] addr_d [DEPTH];
   logic [LINE_W-1:0]  data_q [DEPTH];
   logic [LINE_W-1:0]  data_d [DEPTH];

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (we) begin
         addr_d[waddr] = wr_addr;
         data_d[waddr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign ent_addr[i*LINE_AW +: LINE_AW] = addr_q[i];
      assign ent_data[i*LINE_W  +: LINE_W]  = data_q[i];
   end

endmodule

// File: rtl/evict_buffer.sv
// evict_buffer: write-back evict buffer between the L1 controller and main memory.
// Dirty lines are queued in a circular FIFO and drained over a req/ack write
// port with a mandatory one-cycle turnaround. A combinational lookup lets a
// FILL forward data from a pending eviction. A flush handshake drains all.
// Ports:
//   enq_*        - evicted-line input (valid/ready)
//   mm_wr_*      - main-memory write port (req held until one-cycle ack)
//   lookup_*     - FILL-path address probe, youngest matching entry wins
//   flush        - drain request; flush_done pulses once drained and idle
//   count/empty/full - occupancy, from registered state
module evict_buffer
   import evict_buffer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LINE_AW = EVB_LINE_AW,
   parameter int LINE_W  = EVB_LINE_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [LINE_AW-1:0]       enq_addr,
   input  logic [LINE_W-1:0]        enq_data,
   output logic                     mm_wr_req,
   output logic [LINE_AW-1:0]       mm_wr_addr,
   output logic [LINE_W-1:0]        mm_wr_data,
   input  logic                     mm_wr_ack,
   input  logic [LINE_AW-1:0]       lookup_addr,
   output logic                     lookup_hit,
   output logic [LINE_W-1:0]        lookup_data,
   input  logic                     flush,
   output logic                     flush_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

   logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]    count_q, count_d;
   drain_state_e   state_q, state_d;
   logic           flush_pending_q, flush_pending_d;
   logic           enq_fire, pop_fire;
   logic [PW-1:0]  idx;

   logic [DEPTH*LINE_AW-1:0] ent_addr;
   logic [DEPTH*LINE_W-1:0]  ent_data;

   evb_entry_ram #(
      .DEPTH   (DEPTH),
      .LINE_AW (LINE_AW),
      .LINE_W  (LINE_W),
      .PW      (PW)
   ) u_ram (
      .clk      (clk),
      .we       (enq_fire),
      .waddr    (wp_q),
      .wr_addr  (enq_addr),
      .wr_data  (enq_data),
      .ent_addr (ent_addr),
      .ent_data (ent_data)
   );

   // Status is a pure function of registered state, so enq_ready never
   // depends combinationally on mm_wr_ack.
   assign count      = count_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_FULL);
   assign enq_ready  = !full && !flush_pending_q;
   assign enq_fire   = enq_valid && enq_ready;
   assign mm_wr_req  = (state_q == D_REQ);
   assign mm_wr_addr = ent_addr[rp_q*LINE_AW +: LINE_AW];
   assign mm_wr_data = ent_data[rp_q*LINE_W  +: LINE_W];
   assign flush_done = flush_pending_q && empty && (state_q == D_IDLE);

   // Drain FSM: D_GAP forces a dead cycle on the memory port after every ack.
   always_comb begin
      state_d  = state_q;
      pop_fire = 1'b0;
      case (state_q)
         D_IDLE: if (!empty) state_d = D_REQ;
         D_REQ: begin
            if (mm_wr_ack) begin
               pop_fire = 1'b1;
               state_d  = D_GAP;
            end
         end
         D_GAP:   state_d = D_IDLE;
         default: state_d = D_IDLE;
      endcase
   end

   always_comb begin
      wp_d    = enq_fire ? wp_q + PTR_ONE : wp_q;
      rp_d    = pop_fire ? rp_q + PTR_ONE : rp_q;
      count_d = count_q;
      if (enq_fire && !pop_fire)
         count_d = count_q + CNT_ONE;
      else if (!enq_fire && pop_fire)
         count_d = count_q - CNT_ONE;
      // A flush arriving while one is pending (including the done cycle) is dropped.
      flush_pending_d = flush_done ? 1'b0 : (flush_pending_q || flush);
   end

   // Walk oldest to youngest over occupied slots; later matches overwrite
   // earlier ones so the youngest duplicate wins.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rp_q + PW'(k);
         if (((PW+1)'(k) < count_q) &&
             (ent_addr[idx*LINE_AW +: LINE_AW] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = ent_data[idx*LINE_W +: LINE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q            <= '0;
         rp_q            <= '0;
         count_q         <= '0;
         state_q         <= D_IDLE;
         flush_pending_q <= 1'b0;
      end else begin
         wp_q            <= wp_d;
         rp_q            <= rp_d;
         count_q         <= count_d;
         state_q         <= state_d;
         flush_pending_q <= flush_pending_d;
      end
   end

endmodule

// File: tb/tb_evict_buffer.sv
// Randomized scoreboard bench for evict_buffer. The reference keeps pending
// lines in a queue (push on accepted enqueue, pop on acked write) and derives
// request timing from the documented turnaround rules.
module tb_evict_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 26;
   localparam int DW    = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enq_valid = 1'b0;
   logic          enq_ready;
   logic [AW-1:0] enq_addr = '0;
   logic [DW-1:0] enq_data = '0;
   logic          mm_wr_req;
   logic [AW-1:0] mm_wr_addr;
   logic [DW-1:0] mm_wr_data;
   logic          mm_wr_ack = 1'b0;
   logic [AW-1:0] lookup_addr = '0;
   logic          lookup_hit;
   logic [DW-1:0] lookup_data;
   logic          flush = 1'b0;
   logic          flush_done;
   logic [2:0]    count;
   logic          empty;
   logic          full;

   evict_buffer #(.DEPTH(DEPTH), .LINE_AW(AW), .LINE_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
      .mm_wr_req(mm_wr_req), .mm_wr_addr(mm_wr_addr), .mm_wr_data(mm_wr_data), .mm_wr_ack(mm_wr_ack),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
      .flush(flush), .flush_done(flush_done),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ack_pct = 0;
   int writes = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];        // lines still owned by the buffer, oldest first
   bit   pend_m = 0;  // flush outstanding
   bit   req_m  = 0;  // write request expected this cycle
   int   gap_m  = 0;  // 2: turnaround cycle after ack, 1: idle cycle after that

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Monitor / reference model: compare at negedge, then advance the model to
   // the state the next rising edge will produce.
   always @(negedge clk) begin
      int            cnt;
      bit            rdy_e, idle_e, done_e, hit_e, ef, pf, req_n;
      logic [DW-1:0] ld_e;
      if (!rst_n) begin
         q.delete();
         pend_m = 0; req_m = 0; gap_m = 0;
         chk("rst_enq_ready", enq_ready, 1);
         chk("rst_mm_wr_req", mm_wr_req, 0);
         chk("rst_lookup_hit", lookup_hit, 0);
         chk("rst_lookup_data", lookup_data, 0);
         chk("rst_flush_done", flush_done, 0);
         chk("rst_count", count, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
      end else begin
         cnt    = q.size();
         rdy_e  = (cnt < DEPTH) && !pend_m;
         idle_e = !req_m && (gap_m != 2);
         done_e = pend_m && (cnt == 0) && idle_e;
         hit_e  = 0;
         ld_e   = '0;
         for (int i = cnt - 1; i >= 0; i--)
            if (q[i].a == lookup_addr) begin
               hit_e = 1; ld_e = q[i].d; break;
            end
         chk("count", count, cnt);
         chk("empty", empty, cnt == 0);
         chk("full", full, cnt == DEPTH);
         chk("enq_ready", enq_ready, rdy_e);
         chk("mm_wr_req", mm_wr_req, req_m);
         chk("flush_done", flush_done, done_e);
         chk("lookup_hit", lookup_hit, hit_e);
         chk("lookup_data", lookup_data, ld_e);
         if (req_m && cnt > 0) begin
            chk("mm_wr_addr", mm_wr_addr, q[0].a);
            chk("mm_wr_data", mm_wr_data, q[0].d);
         end
         ef = enq_valid && rdy_e;
         pf = req_m && mm_wr_ack && (cnt > 0);
         if (pf) begin
            void'(q.pop_front());
            writes++;
         end
         if (ef) q.push_back('{a: enq_addr, d: enq_data});
         if (pf) begin
            req_n = 0; gap_m = 2;
         end else if (gap_m == 2) begin
            req_n = 0; gap_m = 1;
         end else begin
            req_n = req_m || (cnt != 0); gap_m = 0;
         end
         req_m  = req_n;
         pend_m = done_e ? 1'b0 : (pend_m || flush);
      end
   end

   // Memory model: ack a pending request with probability ack_pct, plus rare
   // stray acks while no request is up (these must be ignored).
   initial begin
      forever begin
         @(posedge clk); #1;
         if (mm_wr_req) mm_wr_ack = ($urandom_range(99) < ack_pct);
         else           mm_wr_ack = ($urandom_range(99) < 5);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   function automatic logic [DW-1:0] rnd_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic wait_drained(input string nm);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (empty && enq_ready && !mm_wr_req) begin ok = 1; break; end
         cyc();
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s: got busy expected drained", nm); end
   endtask

   initial begin
      bit seen;
      repeat (3) cyc();
      rst_n = 1;
      cyc();

      // Single line, memory answers a few cycles after the request rises.
      enq_valid = 1; enq_addr = 26'h00004; enq_data = {8{32'hA5A5_0004}}; lookup_addr = 26'h00004;
      cyc();
      enq_valid = 0;
      repeat (3) cyc();
      ack_pct = 100;
      wait_drained("single_drain");
      ack_pct = 0;

      // Memory stalled: fill to full, duplicates at 26'h10, extra offers refused.
      lookup_addr = 26'h00010;
      for (int i = 0; i < 6; i++) begin
         enq_valid = 1;
         enq_addr  = (i < 2) ? 26'h00010 : AW'(32 + i);
         enq_data  = rnd_line();
         cyc();
      end
      enq_valid = 0;
      repeat (3) cyc();
      ack_pct = 100;
      wait_drained("full_drain");

      // Random traffic over a small address space to force duplicate hits,
      // concurrent enqueue/pop and pointer wrap.
      ack_pct = 35;
      for (int i = 0; i < 1500; i++) begin
         enq_valid   = $urandom_range(1);
         enq_addr    = AW'($urandom_range(7));
         enq_data    = rnd_line();
         lookup_addr = AW'($urandom_range(7));
         flush       = ($urandom_range(59) == 0);
         cyc();
         flush = 0;
      end
      enq_valid = 0;
      ack_pct = 100;
      wait_drained("random_drain");

      // Flush with three lines queued.
      ack_pct = 0;
      for (int i = 0; i < 3; i++) begin
         enq_valid = 1; enq_addr = AW'(100 + i); enq_data = rnd_line();
         cyc();
      end
      enq_valid = 0;
      flush = 1;
      cyc();
      flush = 0;
      ack_pct = 50;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (flush_done) begin seen = 1; break; end
         cyc();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL flush_timeout: got no flush_done expected pulse"); end
      repeat (3) cyc();

      // Reset in the middle of a request with two lines queued.
      ack_pct = 0;
      for (int i = 0; i < 2; i++) begin
         enq_valid = 1; enq_addr = AW'(200 + i); enq_data = rnd_line();
         cyc();
      end
      enq_valid = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (mm_wr_req) begin seen = 1; break; end
         cyc();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL req_timeout: got no request expected request"); end
      rst_n = 0;
      repeat (2) cyc();
      rst_n = 1;
      ack_pct = 100;
      repeat (10) cyc();

      checks++;
      if (writes < 20) begin errors++; $display("FAIL write_total: got %0d expected at least 20", writes); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
